// File: rtl/seq_alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu_pkg : shared opcode, flag and iteration types for seq_alu  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package seq_alu_pkg;

   localparam int unsigned C_DATA_WIDTH = 16;
   localparam int unsigned C_IMM_WIDTH  = 6;

   typedef enum logic [2:0] {
      OP_NAND = 3'd0,
      OP_NOR  = 3'd1,
      OP_ADC  = 3'd2,
      OP_SBC  = 3'd3,
      OP_LIU  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6,
      OP_MUL  = 3'd7
   } op_e;

   typedef struct packed {
      logic overflow;
      logic parity;
      logic negative;
      logic zero;
      logic carry;
   } flags_t;

   typedef enum logic [1:0] {
      ITER_SHL = 2'd0,
      ITER_SHR = 2'd1,
      ITER_MUL = 2'd2
   } iter_mode_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_iter_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_iter_unit : one-bit-per-cycle shifter and shift-add multiplier |
// | Multiplier built only with SEQ_ALU_MUL_EN.  Rev 1.0                |
// +--------------------------------------------------------------------+
module alu_iter_unit
   import seq_alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = $clog2(C_DATA_WIDTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  iter_mode_e            mode_i,
   input  logic [DATA_WIDTH-1:0] load_i,
`ifdef SEQ_ALU_MUL_EN
   input  logic [DATA_WIDTH-1:0] mcand_i,
`endif
   input  logic [CNT_WIDTH-1:0]  count_i,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  carry_o
);

   iter_mode_e            mode_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_d;

`ifdef SEQ_ALU_MUL_EN
   logic [DATA_WIDTH-1:0] mcand_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] acc_d;
   logic [DATA_WIDTH:0]   w_partial;

   // shift_q doubles as the low product half; its LSB selects the addend
   assign w_partial = {1'b0, acc_q} + (shift_q[0] ? {1'b0, mcand_q} : '0);
`endif

   always_comb begin
      shift_d = (mode_q == ITER_SHL) ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                                     : {1'b0, shift_q[DATA_WIDTH-1:1]};
      carry_o = (mode_q == ITER_SHL) ? shift_q[DATA_WIDTH-1] : shift_q[0];
`ifdef SEQ_ALU_MUL_EN
      acc_d = acc_q;
      if (mode_q == ITER_MUL) begin
         shift_d = {w_partial[0], shift_q[DATA_WIDTH-1:1]};
         acc_d   = w_partial[DATA_WIDTH:1];
         carry_o = |acc_d;
      end
`endif
   end

   assign result_o = shift_d;
   assign done_o   = (cnt_q == CNT_WIDTH'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q  <= ITER_SHL;
         cnt_q   <= '0;
         shift_q <= '0;
`ifdef SEQ_ALU_MUL_EN
         mcand_q <= '0;
         acc_q   <= '0;
`endif
      end else if (start_i) begin
         mode_q  <= mode_i;
         cnt_q   <= count_i;
         shift_q <= load_i;
`ifdef SEQ_ALU_MUL_EN
         mcand_q <= mcand_i;
         acc_q   <= '0;
`endif
      end else if (cnt_q != '0) begin
         cnt_q   <= cnt_q - CNT_WIDTH'(1);
         shift_q <= shift_d;
`ifdef SEQ_ALU_MUL_EN
         acc_q   <= acc_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_alu : handshaked ALU with registered result and iterative ops  |
// | SEQ_ALU_MUL_EN enables the multiplier.  Rev 1.0                    |
// +--------------------------------------------------------------------+
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
   parameter int unsigned IMM_WIDTH  = C_IMM_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  op_e                   op_i,
   input  flags_t                in_flags_i,
   input  logic [IMM_WIDTH-1:0]  in_imm_i,
   input  logic [DATA_WIDTH-1:0] in_src_i,
   input  logic [DATA_WIDTH-1:0] in_dest_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_dest_o,
   output flags_t                out_flags_o
);

   localparam int unsigned DIST_WIDTH = $clog2(DATA_WIDTH);
   localparam int unsigned CNT_WIDTH  = DIST_WIDTH + 1;

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MUL = 2'd2} state_e;
`else
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;
`endif

   state_e                state_q;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_dest_q;
   flags_t                out_flags_q;

   logic                  w_accept;
   logic                  w_is_shift;
   logic                  w_start_iter;
   logic [DIST_WIDTH-1:0] w_dist;
   logic [DATA_WIDTH-1:0] w_addend;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  w_add_ovf;
   logic [DATA_WIDTH-1:0] w_imm_sext;
   logic [DATA_WIDTH-1:0] w_comb_result;
   flags_t                w_comb_flags;
   iter_mode_e            w_iter_mode;
   logic [CNT_WIDTH-1:0]  w_iter_count;
   logic [DATA_WIDTH-1:0] w_iter_load;
   logic                  w_iter_done;
   logic [DATA_WIDTH-1:0] w_iter_result;
   logic                  w_iter_carry;

   function automatic flags_t make_flags(input logic [DATA_WIDTH-1:0] res,
                                         input logic carry, input logic ovf);
      make_flags = '{overflow: ovf, parity: ~^res, negative: res[DATA_WIDTH-1],
                     zero: (res == '0), carry: carry};
   endfunction

   assign in_ready_o = !rst_i && (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
   assign w_accept   = in_valid_i && in_ready_o;
   assign w_is_shift = (op_i == OP_SHL) || (op_i == OP_SHR);
   assign w_dist     = in_src_i[DIST_WIDTH-1:0];

   // SBC reuses the adder with an inverted source; carry-in acts as not-borrow
   assign w_addend   = (op_i == OP_SBC) ? ~in_src_i : in_src_i;
   assign w_sum      = {1'b0, in_dest_i} + {1'b0, w_addend}
                       + {{DATA_WIDTH{1'b0}}, in_flags_i.carry};
   assign w_add_ovf  = (in_dest_i[DATA_WIDTH-1] == w_addend[DATA_WIDTH-1])
                       && (w_sum[DATA_WIDTH-1] != in_dest_i[DATA_WIDTH-1]);
   assign w_imm_sext = {{(DATA_WIDTH-IMM_WIDTH){in_imm_i[IMM_WIDTH-1]}}, in_imm_i};

   always_comb begin
      w_comb_result = in_dest_i;
      w_comb_flags  = in_flags_i;
      case (op_i)
         OP_NAND: begin
            w_comb_result = ~(in_dest_i & in_src_i);
            w_comb_flags  = make_flags(~(in_dest_i & in_src_i), 1'b0, 1'b0);
         end
         OP_NOR: begin
            w_comb_result = ~(in_dest_i | in_src_i);
            w_comb_flags  = make_flags(~(in_dest_i | in_src_i), 1'b0, 1'b0);
         end
         OP_ADC, OP_SBC: begin
            w_comb_result = w_sum[DATA_WIDTH-1:0];
            w_comb_flags  = make_flags(w_sum[DATA_WIDTH-1:0], w_sum[DATA_WIDTH], w_add_ovf);
         end
         OP_LIU: begin
            w_comb_result = (w_imm_sext << IMM_WIDTH)
                            | {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, in_dest_i[IMM_WIDTH-1:0]};
            w_comb_flags  = make_flags(w_comb_result, 1'b0, 1'b0);
         end
         OP_SHL, OP_SHR: begin
            w_comb_flags  = make_flags(in_dest_i, in_flags_i.carry, 1'b0);
         end
         default: begin
            // MUL without the multiplier is a pass-through
            w_comb_result = in_dest_i;
            w_comb_flags  = in_flags_i;
         end
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   assign w_start_iter = w_accept && ((w_is_shift && (w_dist != '0)) || (op_i == OP_MUL));
   assign w_iter_mode  = (op_i == OP_MUL) ? ITER_MUL : ((op_i == OP_SHL) ? ITER_SHL : ITER_SHR);
   assign w_iter_count = (op_i == OP_MUL) ? CNT_WIDTH'(DATA_WIDTH) : {1'b0, w_dist};
   assign w_iter_load  = (op_i == OP_MUL) ? in_src_i : in_dest_i;
`else
   assign w_start_iter = w_accept && w_is_shift && (w_dist != '0);
   assign w_iter_mode  = (op_i == OP_SHL) ? ITER_SHL : ITER_SHR;
   assign w_iter_count = {1'b0, w_dist};
   assign w_iter_load  = in_dest_i;
`endif

   alu_iter_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_iter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (w_start_iter),
      .mode_i   (w_iter_mode),
      .load_i   (w_iter_load),
`ifdef SEQ_ALU_MUL_EN
      .mcand_i  (in_dest_i),
`endif
      .count_i  (w_iter_count),
      .done_o   (w_iter_done),
      .result_o (w_iter_result),
      .carry_o  (w_iter_carry)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_dest_q  <= '0;
         out_flags_q <= '0;
      end else begin
         if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (w_start_iter) begin
`ifdef SEQ_ALU_MUL_EN
                  state_q <= (op_i == OP_MUL) ? S_MUL : S_SHIFT;
`else
                  state_q <= S_SHIFT;
`endif
               end else if (w_accept) begin
                  out_valid_q <= 1'b1;
                  out_dest_q  <= w_comb_result;
                  out_flags_q <= w_comb_flags;
               end
            end
            default: begin
               // The output slot is free here: accepts only happen when it is
               if (w_iter_done) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b1;
                  out_dest_q  <= w_iter_result;
                  out_flags_q <= make_flags(w_iter_result, w_iter_carry, 1'b0);
               end
            end
         endcase
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_dest_o  = out_dest_q;
   assign out_flags_o = out_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_alu : directed self-checking bench for seq_alu (16-bit)     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_seq_alu;
   import seq_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   op_e         op;
   flags_t      in_flags;
   logic [5:0]  in_imm;
   logic [15:0] in_src;
   logic [15:0] in_dest;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_dest;
   flags_t      out_flags;

   int checks = 0;
   int errors = 0;

   seq_alu #(.DATA_WIDTH(16), .IMM_WIDTH(6)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .in_flags_i  (in_flags),
      .in_imm_i    (in_imm),
      .in_src_i    (in_src),
      .in_dest_i   (in_dest),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_dest_o  (out_dest),
      .out_flags_o (out_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      op_e         op;
      logic [15:0] d;
      logic [15:0] s;
      logic [5:0]  imm;
      logic [4:0]  fl;
      logic [15:0] exp_d;
      logic [4:0]  exp_f;
   } vec_t;

   // Offers one op at a negedge and returns just after the edge that accepts it
   task automatic send(input op_e o, input logic [15:0] d, input logic [15:0] s,
                       input logic [5:0] imm, input logic [4:0] fl);
      @(negedge clk);
      op = o; in_dest = d; in_src = s; in_imm = imm; in_flags = fl;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (in_ready) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Latency counted in edges, the accept edge being 1; -1 if never valid
   task automatic wait_out(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = OP_NAND; in_flags = '0; in_imm = '0; in_src = '0; in_dest = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_dest !== 16'h0000) begin errors++; $display("FAIL reset_dest: got %h want 0000", out_dest); end
      checks++; if (out_flags !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b want 00000", out_flags); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b want 0", in_ready); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_adc();
      int lat;
      send(OP_ADC, 16'h7FFF, 16'h0001, 6'h0, 5'b00000);
      wait_out(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL adc_latency: got %0d want 1", lat); end
      checks++; if (out_dest !== 16'h8000) begin errors++; $display("FAIL adc_dest: got %h want 8000", out_dest); end
      checks++; if (out_flags !== 5'b10100) begin errors++; $display("FAIL adc_flags: got %b want 10100", out_flags); end
   endtask

   task automatic test_sbc();
      int lat;
      send(OP_SBC, 16'h0005, 16'h0005, 6'h0, 5'b00001);
      wait_out(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL sbc_latency: got %0d want 1", lat); end
      checks++; if (out_dest !== 16'h0000) begin errors++; $display("FAIL sbc_dest: got %h want 0000", out_dest); end
      checks++; if (out_flags !== 5'b01011) begin errors++; $display("FAIL sbc_flags: got %b want 01011", out_flags); end
   endtask

   task automatic test_shift();
      int lat;
      send(OP_SHL, 16'h8001, 16'h0001, 6'h0, 5'b00000);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL shl1_ready_busy: got %b want 0", in_ready); end
      wait_out(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL shl1_latency: got %0d want 2", lat); end
      checks++; if (out_dest !== 16'h0002) begin errors++; $display("FAIL shl1_dest: got %h want 0002", out_dest); end
      checks++; if (out_flags !== 5'b00001) begin errors++; $display("FAIL shl1_flags: got %b want 00001", out_flags); end

      send(OP_SHR, 16'h8018, 16'h0004, 6'h0, 5'b00000);
      in_dest = 16'hFFFF; in_src = 16'h000F;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL shr4_ready_busy: got %b want 0", in_ready); end
      wait_out(lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL shr4_latency: got %0d want 5", lat); end
      checks++; if (out_dest !== 16'h0801) begin errors++; $display("FAIL shr4_dest: got %h want 0801", out_dest); end
      checks++; if (out_flags !== 5'b01001) begin errors++; $display("FAIL shr4_flags: got %b want 01001", out_flags); end

      send(OP_SHL, 16'h8001, 16'h0000, 6'h0, 5'b00001);
      wait_out(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL shl0_latency: got %0d want 1", lat); end
      checks++; if (out_dest !== 16'h8001) begin errors++; $display("FAIL shl0_dest: got %h want 8001", out_dest); end
      checks++; if (out_flags !== 5'b01101) begin errors++; $display("FAIL shl0_flags: got %b want 01101", out_flags); end
   endtask

   task automatic test_back_to_back();
      vec_t v [5];
      v[0] = '{OP_LIU,  16'h00AB, 16'h0000, 6'b100001, 5'b00000, 16'hF86B, 5'b01100};
      v[1] = '{OP_ADC,  16'hFFFF, 16'h0001, 6'h00,     5'b00000, 16'h0000, 5'b01011};
      v[2] = '{OP_NOR,  16'hFFFF, 16'h0000, 6'h00,     5'b00000, 16'h0000, 5'b01010};
      v[3] = '{OP_ADC,  16'h0001, 16'h0002, 6'h00,     5'b00001, 16'h0004, 5'b00000};
      v[4] = '{OP_NAND, 16'h0F0F, 16'h00FF, 6'h00,     5'b00000, 16'hFFF0, 5'b01100};
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         op = v[i].op; in_dest = v[i].d; in_src = v[i].s; in_imm = v[i].imm; in_flags = v[i].fl;
         in_valid = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
         checks++; if (out_dest !== v[i].exp_d) begin errors++; $display("FAIL b2b_dest[%0d]: got %h want %h", i, out_dest, v[i].exp_d); end
         checks++; if (out_flags !== v[i].exp_f) begin errors++; $display("FAIL b2b_flags[%0d]: got %b want %b", i, out_flags, v[i].exp_f); end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(OP_NAND, 16'h0F0F, 16'h00FF, 6'h0, 5'b00000);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
      op = OP_NOR; in_dest = 16'h0F00; in_src = 16'h00F0; in_flags = 5'b00000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dest !== 16'hFFF0 || out_flags !== 5'b01100) begin
            errors++;
            $display("FAIL bp_hold[%0d]: ready=%b valid=%b dest=%h flags=%b want 0 1 fff0 01100",
                     i, in_ready, out_valid, out_dest, out_flags);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
      checks++; if (out_dest !== 16'hF00F) begin errors++; $display("FAIL bp_next_dest: got %h want f00f", out_dest); end
   endtask

   task automatic test_mul();
      int lat;
`ifdef SEQ_ALU_MUL_EN
      send(OP_MUL, 16'h0123, 16'h0010, 6'h0, 5'b00000);
      in_dest = 16'hFFFF; in_src = 16'hFFFF;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul1_ready_busy: got %b want 0", in_ready); end
      wait_out(lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL mul1_latency: got %0d want 17", lat); end
      checks++; if (out_dest !== 16'h1230) begin errors++; $display("FAIL mul1_dest: got %h want 1230", out_dest); end
      checks++; if (out_flags !== 5'b01000) begin errors++; $display("FAIL mul1_flags: got %b want 01000", out_flags); end

      send(OP_MUL, 16'h4000, 16'h0004, 6'h0, 5'b00000);
      wait_out(lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL mul2_latency: got %0d want 17", lat); end
      checks++; if (out_dest !== 16'h0000) begin errors++; $display("FAIL mul2_dest: got %h want 0000", out_dest); end
      checks++; if (out_flags !== 5'b01011) begin errors++; $display("FAIL mul2_flags: got %b want 01011", out_flags); end
`else
      send(OP_MUL, 16'h1234, 16'h0010, 6'h0, 5'b10101);
      wait_out(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL mulnop_latency: got %0d want 1", lat); end
      checks++; if (out_dest !== 16'h1234) begin errors++; $display("FAIL mulnop_dest: got %h want 1234", out_dest); end
      checks++; if (out_flags !== 5'b10101) begin errors++; $display("FAIL mulnop_flags: got %b want 10101", out_flags); end
`endif
   endtask

   task automatic test_reset_mid_op();
      int lat;
      int stale;
      send(OP_NAND, 16'h0F0F, 16'h00FF, 6'h0, 5'b00000);
      wait_out(lat);
      checks++; if (out_dest !== 16'hFFF0) begin errors++; $display("FAIL rmid_pre_dest: got %h want fff0", out_dest); end
`ifdef SEQ_ALU_MUL_EN
      send(OP_MUL, 16'h00FF, 16'h00FF, 6'h0, 5'b00000);
`else
      send(OP_SHL, 16'h00FF, 16'h000F, 6'h0, 5'b00000);
`endif
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b want 0", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
      checks++; if (out_dest !== 16'h0000) begin errors++; $display("FAIL rmid_dest: got %h want 0000", out_dest); end
      checks++; if (out_flags !== 5'b00000) begin errors++; $display("FAIL rmid_flags: got %b want 00000", out_flags); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b want 1", in_ready); end
      stale = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale++;
      end
      checks++; if (stale !== 0) begin errors++; $display("FAIL rmid_stale_result: got %0d valid cycles want 0", stale); end
   endtask

   initial begin
      test_reset();
      test_adc();
      test_sbc();
      test_shift();
      test_back_to_back();
      test_backpressure();
      test_mul();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
